alu_share_arb: RTL and testbench

- Two-requester arbiter and sequencer that time-shares the single 32-bit `alu` datapath, e.g. the main execute path and a branch/address helper unit.
- Each requester hands over an operation (A, B, ALUOp, PC) on a valid/ready handshake.
- The block registers the winning request, drives the ALU from that register, then captures the ALU result and flags into a response register.
- Fixed 2-stage pipeline with full backpressure; each response carries the ID of the requester that issued it.

---
 rtl/alu_share_arb.sv | 115 +++++++++++
 tb/tb_alu_share_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer sharing one ALU: issue register (S1) drives
// the ALU, response register (S2) captures the result; full backpressure.
module alu_share_arb #(
  parameter int ARB_MODE = 0,
  parameter int OP_W     = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [OP_W-1:0] req0_op,
  input  logic [31:0]     req0_pc,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [OP_W-1:0] req1_op,
  input  logic [31:0]     req1_pc,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic [31:0]     alu_pc,
  input  logic [31:0]     alu_c,
  input  logic            alu_zero,
  input  logic            alu_sign,
  input  logic            alu_overflow,
  input  logic            alu_carry,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [31:0]     rsp_c,
  output logic [3:0]      rsp_flags,
  output logic            busy
);
  localparam logic [OP_W-1:0] ALU_NOP = '0;

  typedef struct packed {
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     pc;
    logic [OP_W-1:0] op;
  } req_t;

  logic        v1, id1, v2, id2, last_n;
  req_t        s1, gnt_req;
  logic [31:0] c2;
  logic [3:0]  flags2;
  logic        s2_free, s1_free, g0, g1;

  always_comb begin
    s2_free = !v2 | rsp_ready;
    s1_free = !v1 | s2_free;
    if (ARB_MODE != 0) begin
      g0 = req0_valid;
      g1 = req1_valid & !req0_valid;
    end else begin
      // last_n = 1 hands priority to req1 when both contend
      g0 = req0_valid & (!req1_valid | !last_n);
      g1 = req1_valid & (!req0_valid | last_n);
    end
    gnt_req = g1 ? '{a: req1_a, b: req1_b, pc: req1_pc, op: req1_op}
                 : '{a: req0_a, b: req0_b, pc: req0_pc, op: req0_op};
  end

  // Gate with rstn so readies drop the moment reset asserts.
  assign req0_ready = rstn & s1_free & g0;
  assign req1_ready = rstn & s1_free & g1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1     <= 1'b0;
      id1    <= 1'b0;
      s1     <= '{a: '0, b: '0, pc: '0, op: ALU_NOP};
      last_n <= 1'b0;
    end else if (s1_free) begin
      if (g0 | g1) begin
        v1     <= 1'b1;
        id1    <= g1;
        s1     <= gnt_req;
        last_n <= !g1;
      end else begin
        v1    <= 1'b0;
        s1.op <= ALU_NOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2     <= 1'b0;
      id2    <= 1'b0;
      c2     <= '0;
      flags2 <= '0;
    end else if (v1 & s2_free) begin
      v2     <= 1'b1;
      id2    <= id1;
      c2     <= alu_c;
      flags2 <= {alu_zero, alu_sign, alu_overflow, alu_carry};
    end else if (rsp_ready) begin
      v2 <= 1'b0;
    end
  end

  assign alu_a     = s1.a;
  assign alu_b     = s1.b;
  assign alu_op    = s1.op;
  assign alu_pc    = s1.pc;
  assign rsp_valid = v2;
  assign rsp_id    = id2;
  assign rsp_c     = c2;
  assign rsp_flags = flags2;
  assign busy      = v1 | v2;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU stand-in, scoreboard of accepted
// ops checked in order against responses, plus per-scenario inline checks.
module tb_alu_share_arb;
  localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2,
                         OP_BLTU = 5'd3, OP_AUIPC = 5'd4;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req0_pc, req1_a, req1_b, req1_pc;
  logic [4:0]  req0_op, req1_op;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [31:0] alu_a, alu_b, alu_pc, alu_c, rsp_c;
  logic [4:0]  alu_op;
  logic [3:0]  af, rsp_flags;

  logic        r10_ready, r11_ready, rsp1_valid, rsp1_id, busy1;
  logic [31:0] alu1_a, alu1_b, alu1_pc, alu1_c, rsp1_c;
  logic [4:0]  alu1_op;
  logic [3:0]  af1, rsp1_flags;

  int total = 0, bad = 0;
  logic [36:0] sb[$];
  logic [36:0] sb_exp;

  // Returns {zero, sign, overflow, carry, c}
  function automatic logic [35:0] alu_f(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                        logic [31:0] pc);
    logic [32:0] s;
    logic [31:0] c;
    logic ov, cy;
    ov = 1'b0; cy = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; c = s[31:0]; cy = s[32];
        ov = (a[31] == b[31]) && (c[31] != a[31]);
      end
      OP_SUB, OP_BLTU: begin
        c = a - b; cy = (a < b);
        ov = (a[31] != b[31]) && (c[31] != a[31]);
      end
      OP_AUIPC: c = pc + b;
      default:  c = 32'd0;
    endcase
    return {c == 32'd0, c[31], ov, cy, c};
  endfunction

  assign {af, alu_c}   = alu_f(alu_op, alu_a, alu_b, alu_pc);
  assign {af1, alu1_c} = alu_f(alu1_op, alu1_a, alu1_b, alu1_pc);

  alu_share_arb #(.ARB_MODE(0), .OP_W(5)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_pc(req0_pc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_pc(req1_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_pc(alu_pc), .alu_c(alu_c),
    .alu_zero(af[3]), .alu_sign(af[2]), .alu_overflow(af[1]), .alu_carry(af[0]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  alu_share_arb #(.ARB_MODE(1), .OP_W(5)) dut_fp (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(r10_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_pc(req0_pc),
    .req1_valid(req1_valid), .req1_ready(r11_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_pc(req1_pc),
    .alu_a(alu1_a), .alu_b(alu1_b), .alu_op(alu1_op), .alu_pc(alu1_pc), .alu_c(alu1_c),
    .alu_zero(af1[3]), .alu_sign(af1[2]), .alu_overflow(af1[1]), .alu_carry(af1[0]),
    .rsp_valid(rsp1_valid), .rsp_ready(rsp_ready), .rsp_id(rsp1_id), .rsp_c(rsp1_c),
    .rsp_flags(rsp1_flags), .busy(busy1)
  );

  // Scoreboard for the round-robin instance: push on accept, pop on response.
  always @(negedge clk) begin
    if (rstn) begin
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got id=%0d c=%h flags=%b, none expected",
                   rsp_id, rsp_c, rsp_flags);
        end else begin
          sb_exp = sb.pop_front();
          if ({rsp_id, rsp_flags, rsp_c} !== sb_exp) begin
            bad++;
            $display("FAIL sb_rsp: got id=%0d flags=%b c=%h want id=%0d flags=%b c=%h",
                     rsp_id, rsp_flags, rsp_c, sb_exp[36], sb_exp[35:32], sb_exp[31:0]);
          end
        end
      end
      if (req0_valid && req0_ready) sb.push_back({1'b0, alu_f(req0_op, req0_a, req0_b, req0_pc)});
      if (req1_valid && req1_ready) sb.push_back({1'b1, alu_f(req1_op, req1_a, req1_b, req1_pc)});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set0(logic v, logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] pc);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_pc = pc;
  endtask

  task automatic set1(logic v, logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] pc);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_pc = pc;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0; #2; sb.delete(); rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rsp_ready = 1'b1;
    set0(1'b1, OP_ADD, 32'd9, 32'd9, 32'd9);
    set1(1'b1, OP_SUB, 32'd9, 32'd9, 32'd9);
    #12;
    total++;
    if ({rsp_valid, rsp_id, rsp_c, rsp_flags, busy} !== 39'd0) begin
      bad++; $display("FAIL reset_rsp: got v=%b id=%b c=%h f=%b busy=%b want all 0",
                      rsp_valid, rsp_id, rsp_c, rsp_flags, busy);
    end
    total++;
    if ({req0_ready, req1_ready, r10_ready, r11_ready} !== 4'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0000",
                      {req0_ready, req1_ready, r10_ready, r11_ready});
    end
    total++;
    if ({alu_a, alu_b, alu_pc, alu_op} !== 101'd0) begin
      bad++; $display("FAIL reset_alu: got a=%h b=%h pc=%h op=%0d want 0",
                      alu_a, alu_b, alu_pc, alu_op);
    end
    set0(1'b0, OP_NOP, 0, 0, 0);
    set1(1'b0, OP_NOP, 0, 0, 0);
    @(negedge clk); rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    set0(1'b1, OP_ADD, 32'd5, 32'd7, 32'd0);
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready: got %b want 1", req0_ready);
    end
    step(); req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_early: got rsp_valid=%b want 0", rsp_valid);
    end
    step();
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_flags, rsp_c} !== {1'b1, 1'b0, 4'b0000, 32'd12}) begin
      bad++; $display("FAIL single_rsp: got v=%b id=%b f=%b c=%0d want v=1 id=0 f=0000 c=12",
                      rsp_valid, rsp_id, rsp_flags, rsp_c);
    end
    step();
  endtask

  task automatic test_round_robin();
    pulse_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        set0(1'b1, OP_ADD, 32'd10, 32'd20, 32'd0);
        set1(1'b1, OP_SUB, 32'd50, 32'd8, 32'd0);
      end
      if (i == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
      if (i < 4) begin
        total++;
        if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready},
                          (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        total++;
        if ({r10_ready, r11_ready} !== 2'b10) begin
          bad++; $display("FAIL fp_grant[%0d]: got %b want 10", i, {r10_ready, r11_ready});
        end
      end
      if (i >= 2) begin
        total++;
        if ({rsp_valid, rsp_id} !== {1'b1, 1'(i % 2)}) begin
          bad++; $display("FAIL rr_rsp_id[%0d]: got v=%b id=%b want v=1 id=%0d",
                          i, rsp_valid, rsp_id, i % 2);
        end
        total++;
        if ({rsp1_valid, rsp1_id} !== 2'b10) begin
          bad++; $display("FAIL fp_rsp_id[%0d]: got v=%b id=%b want v=1 id=0",
                          i, rsp1_valid, rsp1_id);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int acc, n;
    acc = 0; n = 0;
    step();
    rsp_ready = 1'b0;
    set1(1'b1, OP_SUB, 32'd3, 32'd3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req1_ready) acc++;
      if (i == 4) begin
        total++;
        if ({rsp_valid, rsp_id, rsp_flags, rsp_c} !== {1'b1, 1'b1, 4'b1000, 32'd0}) begin
          bad++; $display("FAIL bp_hold: got v=%b id=%b f=%b c=%h want v=1 id=1 f=1000 c=0",
                          rsp_valid, rsp_id, rsp_flags, rsp_c);
        end
        total++;
        if ({req0_ready, req1_ready, busy} !== 3'b001) begin
          bad++; $display("FAIL bp_ready: got r0=%b r1=%b busy=%b want 0 0 1",
                          req0_ready, req1_ready, busy);
        end
      end
      step();
    end
    total++;
    if (acc != 2) begin
      bad++; $display("FAIL bp_accepted: got %0d want 2", acc);
    end
    req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
      step();
    end
    total++;
    if (n != 2 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_drain: got %0d responses busy=%b want 2 busy=0", n, busy);
    end
  endtask

  task automatic test_flags();
    logic [4:0]  ops[3]   = '{OP_ADD, OP_BLTU, OP_AUIPC};
    logic [31:0] as[3]    = '{32'h7FFF_FFFF, 32'd1, 32'd0};
    logic [31:0] bs[3]    = '{32'd1, 32'd2, 32'h1000};
    logic [31:0] pcs[3]   = '{32'd0, 32'd0, 32'h100};
    logic [31:0] cs[3]    = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1100};
    logic [3:0]  fs[3]    = '{4'b0110, 4'b0101, 4'b0000};
    for (int k = 0; k < 3; k++) begin
      set0(1'b1, ops[k], as[k], bs[k], pcs[k]);
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1) begin
        bad++; $display("FAIL flags_ready[%0d]: got %b want 1", k, req0_ready);
      end
      step(); req0_valid = 1'b0;
      step();
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_flags, rsp_c} !== {1'b1, fs[k], cs[k]}) begin
        bad++; $display("FAIL flags_rsp[%0d]: got v=%b f=%b c=%h want v=1 f=%b c=%h",
                        k, rsp_valid, rsp_flags, rsp_c, fs[k], cs[k]);
      end
      step();
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    n = 0;
    rsp_ready = 1'b0;
    set0(1'b1, OP_ADD, 32'd1, 32'd1, 32'd0);
    step();
    set0(1'b1, OP_ADD, 32'd2, 32'd2, 32'd0);
    step();
    #1;
    total++;
    if ({rsp_valid, busy} !== 2'b11) begin
      bad++; $display("FAIL mid_pre: got v=%b busy=%b want 1 1", rsp_valid, busy);
    end
    rstn = 1'b0;
    #1;
    sb.delete();
    total++;
    if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0000 || alu_op !== OP_NOP) begin
      bad++; $display("FAIL mid_async: got v=%b busy=%b r0=%b r1=%b op=%0d want all 0",
                      rsp_valid, busy, req0_ready, req1_ready, alu_op);
    end
    req0_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rstn = 1'b1;
    set1(1'b1, OP_AUIPC, 32'd0, 32'd4, 32'h200);
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL mid_post_ready: got %b want 1", req1_ready);
    end
    step(); req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL mid_stale: got rsp_valid=%b want 0", rsp_valid);
    end
    step();
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_c} !== {1'b1, 1'b1, 32'h204}) begin
      bad++; $display("FAIL mid_post_rsp: got v=%b id=%b c=%h want v=1 id=1 c=204",
                      rsp_valid, rsp_id, rsp_c);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      if (rsp_valid) n++;
    end
    total++;
    if (n != 0) begin
      bad++; $display("FAIL mid_extra: got %0d extra responses want 0", n);
    end
    step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({alu_op, busy, rsp_valid} !== {OP_NOP, 2'b00}) begin
        bad++; $display("FAIL idle[%0d]: got op=%0d busy=%b v=%b want op=0 busy=0 v=0",
                        i, alu_op, busy, rsp_valid);
      end
      step();
    end
  endtask

  initial begin
    set0(1'b0, OP_NOP, 0, 0, 0);
    set1(1'b0, OP_NOP, 0, 0, 0);
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flags();
    test_reset_midflight();
    test_idle();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
